// File: rtl/naneye_ser_tx_if.sv
// Parallel pixel handshake between a pixel source (master) and the NanEye serializer (slave).
interface naneye_ser_tx_if #(
  parameter int D_WIDTH = 10
);
  logic [D_WIDTH-1:0] PAR_IN;
  logic               PAR_VALID;
  logic               PAR_READY;
  logic               LINE_END;

  modport master (output PAR_IN, output PAR_VALID, output LINE_END, input PAR_READY);
  modport slave  (input PAR_IN, input PAR_VALID, input LINE_END, output PAR_READY);
endinterface

// File: rtl/naneye_ser_tx.sv
// NanEye-style Manchester pixel serializer (IDLE/START/DATA/[PARITY]/STOP/GAP/FSYNC).
// Define TX_PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module naneye_ser_tx #(
  parameter int D_WIDTH         = 10,
  parameter int HALF_BIT_CLKS   = 4,
  parameter int LINE_GAP_BITS   = 3,
  parameter int FSYNC_HALF_BITS = 24
) (
  input  logic             CLOCK,
  input  logic             RESET,
  naneye_ser_tx_if.slave   par_if,
  input  logic             FRAME_SYNC,
  output logic             SER_OUT,
  output logic             TX_ACTIVE,
  output logic             FSYNC_ACTIVE,
  output logic             LINE_DONE
);
  localparam int HB_W     = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
  localparam int MAX_A    = (D_WIDTH > LINE_GAP_BITS) ? D_WIDTH : LINE_GAP_BITS;
  localparam int MAX_BITS = (MAX_A > FSYNC_HALF_BITS) ? MAX_A : FSYNC_HALF_BITS;
  localparam int BC_W     = $clog2(MAX_BITS + 1);

  localparam logic [HB_W-1:0] HB_LAST  = HB_W'(HALF_BIT_CLKS - 1);
  localparam logic [BC_W-1:0] D_LAST   = BC_W'(D_WIDTH - 1);
  localparam logic [BC_W-1:0] GAP_LAST = BC_W'(LINE_GAP_BITS - 1);
  localparam logic [BC_W-1:0] FS_LAST  = BC_W'(FSYNC_HALF_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, GAP, FSYNC
`ifdef TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t             state;
  logic [HB_W-1:0]    hb_cnt;
  logic [BC_W-1:0]    bit_cnt;
  logic               half;
  logic               cur_bit;
  logic [D_WIDTH-1:0] shifter;
  logic               line_q;
  logic [D_WIDTH-1:0] hold_data;
  logic               hold_line;
  logic               hold_full;
  logic               ready_q;
  logic               fs_pending;
`ifdef TX_PARITY_EN
  logic               parity_q;
`endif

  logic hb_end;
  logic decide;
  logic load;

  assign hb_end = (hb_cnt == HB_LAST);
  assign load   = par_if.PAR_VALID && ready_q;

  // Next-word decision points: end of an idle bit, a non-line stop bit, the gap, or the sync level.
  always_comb begin
    decide = 1'b0;
    if (hb_end) begin
      case (state)
        IDLE:    decide = half;
        STOP:    decide = half && !line_q;
        GAP:     decide = half && (bit_cnt == GAP_LAST);
        FSYNC:   decide = (bit_cnt == FS_LAST);
        default: decide = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      hb_cnt     <= '0;
      bit_cnt    <= '0;
      half       <= 1'b0;
      cur_bit    <= 1'b0;
      shifter    <= '0;
      line_q     <= 1'b0;
      hold_data  <= '0;
      hold_line  <= 1'b0;
      hold_full  <= 1'b0;
      ready_q    <= 1'b0;
      fs_pending <= 1'b0;
      SER_OUT    <= 1'b0;
`ifdef TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      ready_q <= !hold_full;
      if (FRAME_SYNC && state != FSYNC) fs_pending <= 1'b1;

      if (!hb_end) begin
        hb_cnt <= hb_cnt + HB_W'(1);
      end else begin
        hb_cnt <= '0;
        if (decide) begin
          half    <= 1'b0;
          bit_cnt <= '0;
          if (fs_pending) begin
            state      <= FSYNC;
            fs_pending <= 1'b0;
            SER_OUT    <= 1'b1;
          end else if (hold_full) begin
            state     <= START;
            cur_bit   <= 1'b1;
            SER_OUT   <= 1'b1;
            shifter   <= hold_data;
            line_q    <= hold_line;
            hold_full <= 1'b0;
            ready_q   <= 1'b1;
`ifdef TX_PARITY_EN
            parity_q  <= ^hold_data;
`endif
          end else begin
            state   <= IDLE;
            cur_bit <= 1'b0;
            SER_OUT <= 1'b0;
          end
        end else if (state == FSYNC) begin
          bit_cnt <= bit_cnt + BC_W'(1);
        end else if (!half) begin
          half    <= 1'b1;
          SER_OUT <= ~cur_bit;
        end else begin
          half <= 1'b0;
          case (state)
            START: begin
              state   <= DATA;
              bit_cnt <= '0;
              cur_bit <= shifter[D_WIDTH-1];
              SER_OUT <= shifter[D_WIDTH-1];
              shifter <= {shifter[D_WIDTH-2:0], 1'b0};
            end
            DATA: begin
              if (bit_cnt == D_LAST) begin
`ifdef TX_PARITY_EN
                state   <= PARITY;
                cur_bit <= parity_q;
                SER_OUT <= parity_q;
`else
                state   <= STOP;
                cur_bit <= 1'b0;
                SER_OUT <= 1'b0;
`endif
              end else begin
                bit_cnt <= bit_cnt + BC_W'(1);
                cur_bit <= shifter[D_WIDTH-1];
                SER_OUT <= shifter[D_WIDTH-1];
                shifter <= {shifter[D_WIDTH-2:0], 1'b0};
              end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
              state   <= STOP;
              cur_bit <= 1'b0;
              SER_OUT <= 1'b0;
            end
`endif
            STOP: begin
              state   <= GAP;
              bit_cnt <= '0;
              cur_bit <= 1'b0;
              SER_OUT <= 1'b0;
            end
            GAP: begin
              bit_cnt <= bit_cnt + BC_W'(1);
              SER_OUT <= 1'b0;
            end
            default: ;
          endcase
        end
      end

      if (load) begin
        hold_data <= par_if.PAR_IN;
        hold_line <= par_if.LINE_END;
        hold_full <= 1'b1;
        ready_q   <= 1'b0;
      end
    end
  end

  assign par_if.PAR_READY = ready_q;
`ifdef TX_PARITY_EN
  assign TX_ACTIVE    = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
`else
  assign TX_ACTIVE    = (state == START) || (state == DATA) || (state == STOP);
`endif
  assign FSYNC_ACTIVE = (state == FSYNC);
  assign LINE_DONE    = (state == GAP) && half && hb_end && (bit_cnt == GAP_LAST);
endmodule

// File: tb/tb_naneye_ser_tx.sv
// Bench for naneye_ser_tx: waveform reference model built from the Manchester/word rules,
// a table of single-word transfers, hand sequences for back-to-back and mid-word reset, then random traffic.
module tb_naneye_ser_tx;
  localparam int DW  = 10;
  localparam int HB  = 2;
  localparam int LG  = 3;
  localparam int FSH = 24;
`ifdef TX_PARITY_EN
  localparam int WB = DW + 3;
`else
  localparam int WB = DW + 2;
`endif
  localparam int WCLK = WB * 2 * HB;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  logic FRAME_SYNC;
  logic SER_OUT, TX_ACTIVE, FSYNC_ACTIVE, LINE_DONE;

  naneye_ser_tx_if #(.D_WIDTH(DW)) par_if ();

  naneye_ser_tx #(
    .D_WIDTH(DW), .HALF_BIT_CLKS(HB), .LINE_GAP_BITS(LG), .FSYNC_HALF_BITS(FSH)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .par_if(par_if), .FRAME_SYNC(FRAME_SYNC),
    .SER_OUT(SER_OUT), .TX_ACTIVE(TX_ACTIVE), .FSYNC_ACTIVE(FSYNC_ACTIVE), .LINE_DONE(LINE_DONE)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed { logic ser; logic tx; logic fs; logic ld; } lvl_t;
  typedef struct {
    logic [DW-1:0] data;
    logic          line;
    logic          fs;
    int            tx_clks;
    int            fs_clks;
    int            ld_pulses;
  } vec_t;

  lvl_t          exp_q[$];
  logic          m_full, m_line, m_fs, m_ready;
  logic [DW-1:0] m_data;
  int n_vec = 0, n_bad = 0;
  int cnt_tx, cnt_fs, cnt_ld, run_tx, max_run;

  function automatic void chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endfunction

  function automatic void push_bit(logic b, logic tx);
    for (int i = 0; i < HB; i++) exp_q.push_back('{b, tx, 1'b0, 1'b0});
    for (int i = 0; i < HB; i++) exp_q.push_back('{~b, tx, 1'b0, 1'b0});
  endfunction

  function automatic void push_word(logic [DW-1:0] d, logic line);
    lvl_t t;
    push_bit(1'b1, 1'b1);
    for (int i = DW - 1; i >= 0; i--) push_bit(d[i], 1'b1);
`ifdef TX_PARITY_EN
    push_bit(^d, 1'b1);
`endif
    push_bit(1'b0, 1'b1);
    if (line) begin
      for (int g = 0; g < LG; g++) push_bit(1'b0, 1'b0);
      t = exp_q.pop_back();
      t.ld = 1'b1;
      exp_q.push_back(t);
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    push_bit(1'b0, 1'b0);
    m_full = 1'b0; m_fs = 1'b0; m_ready = 1'b0; m_line = 1'b0; m_data = '0;
  endfunction

  // One clock: advance the model on pre-edge inputs, then compare all outputs after the edge.
  task automatic step();
    lvl_t cur;
    logic acc, entering_fs;
    cur = exp_q[0];
    acc = par_if.PAR_VALID && m_ready;
    entering_fs = 1'b0;
    void'(exp_q.pop_front());
    if (exp_q.size() == 0) begin
      if (m_fs) begin
        for (int i = 0; i < FSH * HB; i++) exp_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0});
        m_fs = 1'b0;
        entering_fs = 1'b1;
      end else if (m_full) begin
        push_word(m_data, m_line);
        m_full = 1'b0;
      end else begin
        push_bit(1'b0, 1'b0);
      end
    end
    if (FRAME_SYNC && !cur.fs && !entering_fs) m_fs = 1'b1;
    if (acc) begin
      m_full = 1'b1; m_data = par_if.PAR_IN; m_line = par_if.LINE_END;
    end
    m_ready = !m_full;
    @(posedge CLOCK);
    #1;
    chk("ser_out", int'(SER_OUT), int'(exp_q[0].ser));
    chk("tx_active", int'(TX_ACTIVE), int'(exp_q[0].tx));
    chk("fsync_active", int'(FSYNC_ACTIVE), int'(exp_q[0].fs));
    chk("line_done", int'(LINE_DONE), int'(exp_q[0].ld));
    chk("par_ready", int'(par_if.PAR_READY), int'(m_ready));
    cnt_tx += int'(TX_ACTIVE);
    cnt_fs += int'(FSYNC_ACTIVE);
    cnt_ld += int'(LINE_DONE);
    run_tx = TX_ACTIVE ? run_tx + 1 : 0;
    if (run_tx > max_run) max_run = run_tx;
  endtask

  task automatic clr_cnt();
    cnt_tx = 0; cnt_fs = 0; cnt_ld = 0; run_tx = 0; max_run = 0;
  endtask

  task automatic send_word(logic [DW-1:0] d, logic line, logic fs);
    logic done;
    done = 1'b0;
    par_if.PAR_IN = d; par_if.LINE_END = line; par_if.PAR_VALID = 1'b1; FRAME_SYNC = fs;
    for (int i = 0; i < 200 && !done; i++) begin
      done = m_ready;
      step();
      FRAME_SYNC = 1'b0;
    end
    par_if.PAR_VALID = 1'b0; par_if.LINE_END = 1'b0;
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  vec_t tbl[5];
  logic [3:0] pat;
  logic got;

  initial begin
    par_if.PAR_IN = '0; par_if.PAR_VALID = 1'b0; par_if.LINE_END = 1'b0; FRAME_SYNC = 1'b0;
    clr_cnt();
    tbl[0] = '{10'h2A5, 1'b0, 1'b0, WCLK, 0, 0};
    tbl[1] = '{10'h155, 1'b1, 1'b0, WCLK, 0, 1};
    tbl[2] = '{10'h001, 1'b0, 1'b1, WCLK, FSH * HB, 0};
    tbl[3] = '{10'h3FF, 1'b0, 1'b0, WCLK, 0, 0};
    tbl[4] = '{10'h000, 1'b1, 1'b1, WCLK, FSH * HB, 1};

    // Reset state and idle pattern
    model_reset();
    repeat (2) @(posedge CLOCK);
    #1;
    chk("rst_ser", int'(SER_OUT), 0);
    chk("rst_ready", int'(par_if.PAR_READY), 0);
    chk("rst_tx", int'(TX_ACTIVE), 0);
    chk("rst_fs", int'(FSYNC_ACTIVE), 0);
    chk("rst_ld", int'(LINE_DONE), 0);
    pat[3] = SER_OUT;
    RESET = 1'b0;
    step();
    chk("ready_after_rst", int'(par_if.PAR_READY), 1);
    pat[2] = SER_OUT;
    step(); pat[1] = SER_OUT;
    step(); pat[0] = SER_OUT;
    chk("idle_pattern", int'(pat), 4'b0011);
    repeat (8) step();

    // Table of single transfers
    for (int v = 0; v < 5; v++) begin
      clr_cnt();
      send_word(tbl[v].data, tbl[v].line, tbl[v].fs);
      repeat (140) step();
      chk($sformatf("tbl%0d_tx_clks", v), cnt_tx, tbl[v].tx_clks);
      chk($sformatf("tbl%0d_fs_clks", v), cnt_fs, tbl[v].fs_clks);
      chk($sformatf("tbl%0d_ld_pulses", v), cnt_ld, tbl[v].ld_pulses);
    end

    // Back-to-back words with VALID held
    clr_cnt();
    par_if.PAR_VALID = 1'b1; par_if.PAR_IN = 10'h3FF;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin got = m_ready; step(); end
    par_if.PAR_IN = 10'h000;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin got = m_ready; step(); end
    if (!got) chk("b2b_accept_timeout", 0, 1);
    par_if.PAR_VALID = 1'b0;
    repeat (120) step();
    chk("b2b_contiguous_tx", max_run, 2 * WCLK);
    chk("b2b_total_tx", cnt_tx, 2 * WCLK);

    // Reset in the middle of the data field
    clr_cnt();
    send_word(10'h2A5, 1'b0, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      step();
      got = (cnt_tx > 6*HB) && SER_OUT;
    end
    chk("mid_data_reached", int'(got), 1);
    #2 RESET = 1'b1;
    #1;
    chk("async_rst_ser", int'(SER_OUT), 0);
    chk("async_rst_tx", int'(TX_ACTIVE), 0);
    model_reset();
    @(posedge CLOCK);
    #1 RESET = 1'b0;
    clr_cnt();
    repeat (100) step();
    chk("discarded_word_tx", cnt_tx, 0);
    send_word(10'h2A5, 1'b0, 1'b0);
    repeat (80) step();
    chk("post_rst_word_tx", cnt_tx, WCLK);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      par_if.PAR_VALID = ($urandom_range(0, 2) != 0);
      par_if.PAR_IN    = DW'($urandom);
      par_if.LINE_END  = ($urandom_range(0, 4) == 0);
      FRAME_SYNC       = ($urandom_range(0, 80) == 0);
      step();
    end
    par_if.PAR_VALID = 1'b0; FRAME_SYNC = 1'b0;
    repeat (200) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
